// File: rtl/lsu_mem_initiator_pkg.sv
// Shared definitions for the load/store memory initiator: access size codes,
// FSM states and small decode helpers.
package lsu_mem_pkg;

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Access size in bytes; 0 marks an unknown code.
    function automatic logic [2:0] size_from_ctrl(input logic [2:0] ctrl);
        case (ctrl)
            CTRL_B, CTRL_BU: return 3'd1;
            CTRL_H, CTRL_HU: return 3'd2;
            CTRL_W:          return 3'd4;
            default:         return 3'd0;
        endcase
    endfunction

    function automatic logic ctrl_legal(input logic [2:0] ctrl, input logic we);
        case (ctrl)
            CTRL_B, CTRL_H, CTRL_W: return 1'b1;
            CTRL_BU, CTRL_HU:       return !we;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Request/response handshake and byte-lane memory bus of the initiator.
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_ctrl;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: byte enables and write-data placement per beat,
// read-word merge/shift and sign/zero extension.
module lsu_lane_align
    import lsu_mem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  ctrl_i,
    input  logic        beat1_i,
    input  logic [31:0] wdata_i,
    input  logic        split_load_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic        split_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [2:0]  size;
    logic [2:0]  reach;
    logic [7:0]  mask8;
    logic [7:0]  mask_sh;
    logic [63:0] wd64;
    logic [31:0] rd_sh;

    always_comb begin
        size    = size_from_ctrl(ctrl_i);
        reach   = {1'b0, offset_i} + size;
        split_o = reach > 3'd4;

        // Lanes past byte 3 spill into the next word, i.e. the second beat.
        mask8   = (8'd1 << size) - 8'd1;
        mask_sh = mask8 << offset_i;
        be_o    = beat1_i ? mask_sh[7:4] : mask_sh[3:0];

        wd64    = {32'h0, wdata_i} << {offset_i, 3'b000};
        wdata_o = beat1_i ? wd64[63:32] : wd64[31:0];

        rd_sh   = 32'({(split_load_i ? rdata_hi_i : 32'h0), rdata_lo_i} >> {offset_i, 3'b000});

        case (ctrl_i)
            CTRL_B:  rdata_o = {{24{rd_sh[7]}}, rd_sh[7:0]};
            CTRL_H:  rdata_o = {{16{rd_sh[15]}}, rd_sh[15:0]};
            CTRL_W:  rdata_o = rd_sh;
            CTRL_BU: rdata_o = {24'h0, rd_sh[7:0]};
            CTRL_HU: rdata_o = {16'h0, rd_sh[15:0]};
            default: rdata_o = 32'h0;
        endcase
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator: one request at a time, drives a word-indexed byte-lane
// RAM with 1-cycle read latency, splitting misaligned accesses into two beats.
module lsu_mem_initiator
    import lsu_mem_pkg::*;
#(
    parameter int ADDR_W           = 9,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    lsu_mem_initiator_if.master bus
);
    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] w0_q, w0_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              split_q, split_d;
    logic [31:0]       rdata0_q, rdata0_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic              idle;
    logic [1:0]        al_off;
    logic [2:0]        al_ctrl;
    logic [31:0]       al_wdata_in;
    logic              al_split;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;

    // In IDLE the aligner sees the live request so beat 0 is ready at accept.
    assign idle        = (state_q == ST_IDLE);
    assign al_off      = idle ? bus.req_addr[1:0] : off_q;
    assign al_ctrl     = idle ? bus.req_ctrl      : ctrl_q;
    assign al_wdata_in = idle ? bus.req_wdata     : wdata_q;

    lsu_lane_align u_align (
        .offset_i     (al_off),
        .ctrl_i       (al_ctrl),
        .beat1_i      (state_q == ST_BEAT0),
        .wdata_i      (al_wdata_in),
        .split_load_i (split_q),
        .rdata_lo_i   (split_q ? rdata0_q : bus.mem_rdata),
        .rdata_hi_i   (bus.mem_rdata),
        .split_o      (al_split),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        ctrl_d       = ctrl_q;
        off_d        = off_q;
        w0_d         = w0_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        rdata0_d     = rdata0_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_be_d     = 4'b0000;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    ctrl_d  = bus.req_ctrl;
                    off_d   = bus.req_addr[1:0];
                    w0_d    = bus.req_addr[ADDR_W+1:2];
                    wdata_d = bus.req_wdata;
                    split_d = al_split;
                    if (!ctrl_legal(bus.req_ctrl, bus.req_we) ||
                        (al_split && !ALLOW_MISALIGNED)) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_BEAT0;
                        mem_en_d   = 1'b1;
                        mem_we_d   = bus.req_we;
                        mem_be_d   = bus.req_we ? al_be : 4'b0000;
                        mem_addr_d = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we) mem_wdata_d = al_wdata;
                    end
                end
            end
            ST_BEAT0: begin
                if (split_q) begin
                    state_d    = ST_BEAT1;
                    mem_en_d   = 1'b1;
                    mem_we_d   = we_q;
                    mem_be_d   = we_q ? al_be : 4'b0000;
                    mem_addr_d = w0_q + ADDR_W'(1);
                    if (we_q) mem_wdata_d = al_wdata;
                end else if (we_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_BEAT1: begin
                rdata0_d = bus.mem_rdata;
                if (we_q) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = al_rdata;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            ctrl_q       <= 3'b000;
            off_q        <= 2'b00;
            w0_q         <= '0;
            wdata_q      <= 32'h0;
            split_q      <= 1'b0;
            rdata0_q     <= 32'h0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            ctrl_q       <= ctrl_d;
            off_q        <= off_d;
            w0_q         <= w0_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            rdata0_q     <= rdata0_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed scenarios plus random loads/stores
// against a byte-addressed reference memory; a second instance rejects misalignment.
module tb_lsu_mem_initiator;
    import lsu_mem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    lsu_mem_initiator_if #(.ADDR_W(9)) bif ();
    lsu_mem_initiator_if #(.ADDR_W(9)) bif0 ();

    lsu_mem_initiator #(.ADDR_W(9), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bif.master));
    lsu_mem_initiator #(.ADDR_W(9), .ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk (clk), .rst (rst), .bus (bif0.master));

    logic        drv_sel, drv_valid, drv_we;
    logic [2:0]  drv_ctrl;
    logic [31:0] drv_addr, drv_wdata;

    assign bif.req_valid  = drv_valid && !drv_sel;
    assign bif0.req_valid = drv_valid && drv_sel;
    assign bif.req_we     = drv_we;
    assign bif0.req_we    = drv_we;
    assign bif.req_ctrl   = drv_ctrl;
    assign bif0.req_ctrl  = drv_ctrl;
    assign bif.req_addr   = drv_addr;
    assign bif0.req_addr  = drv_addr;
    assign bif.req_wdata  = drv_wdata;
    assign bif0.req_wdata = drv_wdata;
    assign bif0.mem_rdata = 32'h0;

    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_en, o_mem_we;
    logic [31:0] o_resp_rdata, o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic [8:0]  o_mem_addr;
    assign o_req_ready  = drv_sel ? bif0.req_ready  : bif.req_ready;
    assign o_resp_valid = drv_sel ? bif0.resp_valid : bif.resp_valid;
    assign o_resp_err   = drv_sel ? bif0.resp_err   : bif.resp_err;
    assign o_resp_rdata = drv_sel ? bif0.resp_rdata : bif.resp_rdata;
    assign o_mem_en     = drv_sel ? bif0.mem_en     : bif.mem_en;
    assign o_mem_we     = drv_sel ? bif0.mem_we     : bif.mem_we;
    assign o_mem_be     = drv_sel ? bif0.mem_be     : bif.mem_be;
    assign o_mem_addr   = drv_sel ? bif0.mem_addr   : bif.mem_addr;
    assign o_mem_wdata  = drv_sel ? bif0.mem_wdata  : bif.mem_wdata;

    // Synchronous byte-lane RAM attached to the main instance.
    logic [7:0]  ram [0:2047] = '{default: 8'h00};
    logic [31:0] ram_rdata = 32'h0;
    assign bif.mem_rdata = ram_rdata;
    always @(posedge clk) begin
        if (bif.mem_en) begin
            for (int l = 0; l < 4; l++)
                if (bif.mem_we && bif.mem_be[l])
                    ram[{bif.mem_addr, l[1:0]}] <= bif.mem_wdata[8*l +: 8];
            ram_rdata <= {ram[{bif.mem_addr, 2'd3}], ram[{bif.mem_addr, 2'd2}],
                          ram[{bif.mem_addr, 2'd1}], ram[{bif.mem_addr, 2'd0}]};
        end
    end

    // Reference: flat byte memory, 2048 bytes, addresses wrap.
    logic [7:0] ref_mem [0:2047] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_legal(input bit we, input logic [2:0] c);
        if (we) return (c == 3'd0 || c == 3'd1 || c == 3'd2);
        return size_of(c) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = size_of(c);
        for (int i = 0; i < n; i++)
            v[8*i +: 8] = ref_mem[(int'(a[10:0]) + i) % 2048];
        case (c)
            3'd0:    if (v[7])  v = v | 32'hFFFF_FF00;
            3'd1:    if (v[15]) v = v | 32'hFFFF_0000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [2:0] c, input logic [31:0] d);
        for (int i = 0; i < size_of(c); i++)
            ref_mem[(int'(a[10:0]) + i) % 2048] = d[8*i +: 8];
    endtask

    logic [8:0]  b_addr [2];
    logic [3:0]  b_be   [2];
    logic [31:0] b_wd   [2];
    logic        b_we   [2];

    task automatic do_req(input bit sel, input bit we, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int nb,
                          output logic [31:0] rd, output logic err);
        @(negedge clk);
        drv_sel = sel; drv_valid = 1'b1; drv_we = we;
        drv_ctrl = c; drv_addr = a; drv_wdata = d;
        @(posedge clk);
        lat = 0; nb = 0; rd = 32'h0; err = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            drv_valid = 1'b0;
            if (o_mem_en) begin
                if (nb < 2) begin
                    b_addr[nb] = o_mem_addr; b_be[nb] = o_mem_be;
                    b_wd[nb] = o_mem_wdata; b_we[nb] = o_mem_we;
                end
                nb++;
            end
            if (o_resp_valid) begin
                lat = k; rd = o_resp_rdata; err = o_resp_err;
                break;
            end
        end
        if (lat == 0) begin
            check("resp_timeout", 32'(lat), 32'd1);
        end else begin
            @(negedge clk);
            check("resp_one_pulse", 32'(o_resp_valid), 32'd0);
            check("ready_after_resp", 32'(o_req_ready), 32'd1);
        end
    endtask

    int          lat, nb, exp_lat, exp_nb, cnt;
    logic [31:0] rd, exp_rd, a, d;
    logic        err;
    logic [2:0]  c;
    bit          we, lg, sp;

    initial begin
        rst = 1'b1; drv_sel = 1'b0; drv_valid = 1'b0; drv_we = 1'b0;
        drv_ctrl = 3'd0; drv_addr = 32'h0; drv_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(o_req_ready), 32'd1);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_resp_err", 32'(o_resp_err), 32'd0);
        check("rst_resp_rdata", o_resp_rdata, 32'h0);
        check("rst_mem_en", {27'h0, o_mem_en, o_mem_we, o_mem_be}, 32'h0);
        check("rst_mem_addr", 32'(o_mem_addr), 32'h0);
        check("rst_mem_wdata", o_mem_wdata, 32'h0);
        rst = 1'b0;

        do_req(0, 1, CTRL_W, 32'h10, 32'hDEADBEEF, lat, nb, rd, err);
        ref_store(32'h10, CTRL_W, 32'hDEADBEEF);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(err), 32'd0);
        check("sw_nb", 32'(nb), 32'd1);
        check("sw_addr", 32'(b_addr[0]), 32'd4);
        check("sw_be", 32'(b_be[0]), 32'hF);
        check("sw_wd", b_wd[0], 32'hDEADBEEF);
        check("sw_we", 32'(b_we[0]), 32'd1);

        do_req(0, 1, CTRL_B, 32'h13, 32'h000000A5, lat, nb, rd, err);
        ref_store(32'h13, CTRL_B, 32'hA5);
        check("sb_lat", 32'(lat), 32'd2);
        check("sb_be", 32'(b_be[0]), 32'h8);
        check("sb_wd", b_wd[0], 32'hA5000000);
        do_req(0, 0, CTRL_B, 32'h13, 32'h0, lat, nb, rd, err);
        check("lb_lat", 32'(lat), 32'd3);
        check("lb_be", 32'(b_be[0]), 32'h0);
        check("lb_we", 32'(b_we[0]), 32'd0);
        check("lb_rd", rd, 32'hFFFFFFA5);
        do_req(0, 0, CTRL_BU, 32'h13, 32'h0, lat, nb, rd, err);
        check("lbu_rd", rd, 32'h000000A5);

        do_req(0, 1, CTRL_W, 32'h0E, 32'h11223344, lat, nb, rd, err);
        ref_store(32'h0E, CTRL_W, 32'h11223344);
        check("sws_lat", 32'(lat), 32'd3);
        check("sws_nb", 32'(nb), 32'd2);
        check("sws_a0", 32'(b_addr[0]), 32'd3);
        check("sws_be0", 32'(b_be[0]), 32'hC);
        check("sws_wd0", b_wd[0], 32'h33440000);
        check("sws_a1", 32'(b_addr[1]), 32'd4);
        check("sws_be1", 32'(b_be[1]), 32'h3);
        check("sws_wd1", b_wd[1], 32'h00001122);
        do_req(0, 0, CTRL_W, 32'h0E, 32'h0, lat, nb, rd, err);
        check("lws_lat", 32'(lat), 32'd4);
        check("lws_rd", rd, 32'h11223344);

        do_req(0, 1, CTRL_H, 32'h7FF, 32'h00008001, lat, nb, rd, err);
        ref_store(32'h7FF, CTRL_H, 32'h8001);
        check("shw_a0", 32'(b_addr[0]), 32'd511);
        check("shw_be0", 32'(b_be[0]), 32'h8);
        check("shw_wd0", b_wd[0], 32'h01000000);
        check("shw_a1", 32'(b_addr[1]), 32'd0);
        check("shw_be1", 32'(b_be[1]), 32'h1);
        check("shw_wd1", b_wd[1], 32'h00000080);
        do_req(0, 0, CTRL_H, 32'h7FF, 32'h0, lat, nb, rd, err);
        check("lhw_lat", 32'(lat), 32'd4);
        check("lhw_rd", rd, 32'hFFFF8001);

        do_req(0, 0, 3'b011, 32'h0, 32'h0, lat, nb, rd, err);
        check("ill_lat", 32'(lat), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_nb", 32'(nb), 32'd0);
        check("ill_rd", rd, 32'h0);
        do_req(0, 1, CTRL_BU, 32'h4, 32'h12345678, lat, nb, rd, err);
        check("sbu_lat", 32'(lat), 32'd1);
        check("sbu_err", 32'(err), 32'd1);
        check("sbu_nb", 32'(nb), 32'd0);

        // Reset during beat 1 of a split store; both beats reached the RAM.
        @(negedge clk);
        drv_sel = 1'b0; drv_valid = 1'b1; drv_we = 1'b1;
        drv_ctrl = CTRL_W; drv_addr = 32'h21; drv_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        check("rmid_beat0", 32'(o_mem_en), 32'd1);
        @(negedge clk);
        check("rmid_beat1_addr", 32'(o_mem_addr), 32'd9);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_mem_en", 32'(o_mem_en), 32'd0);
        check("rmid_ready", 32'(o_req_ready), 32'd1);
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_resp_valid) cnt++;
        end
        check("rmid_no_resp", 32'(cnt), 32'd0);
        ref_store(32'h21, CTRL_W, 32'hCAFEF00D);
        do_req(0, 0, CTRL_W, 32'h21, 32'h0, lat, nb, rd, err);
        check("rmid_readback", rd, 32'hCAFEF00D);

        do_req(1, 0, CTRL_W, 32'h02, 32'h0, lat, nb, rd, err);
        check("nm_lw_lat", 32'(lat), 32'd1);
        check("nm_lw_err", 32'(err), 32'd1);
        check("nm_lw_nb", 32'(nb), 32'd0);
        do_req(1, 1, CTRL_H, 32'h03, 32'h1234, lat, nb, rd, err);
        check("nm_sh_err", 32'(err), 32'd1);
        check("nm_sh_nb", 32'(nb), 32'd0);
        do_req(1, 1, CTRL_W, 32'h20, 32'h55AA55AA, lat, nb, rd, err);
        check("nm_sw_lat", 32'(lat), 32'd2);
        check("nm_sw_err", 32'(err), 32'd0);
        check("nm_sw_addr", 32'(b_addr[0]), 32'd8);
        do_req(1, 0, CTRL_B, 32'h03, 32'h0, lat, nb, rd, err);
        check("nm_lb_lat", 32'(lat), 32'd3);
        check("nm_lb_err", 32'(err), 32'd0);

        for (int it = 0; it < 300; it++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) c = 3'($urandom_range(0, 7));
            else case ($urandom_range(0, 4))
                0: c = CTRL_B;  1: c = CTRL_H;  2: c = CTRL_W;
                3: c = CTRL_BU; default: c = CTRL_HU;
            endcase
            a = $urandom();
            if ($urandom_range(0, 3) == 0) a[10:0] = 11'($urandom_range(2040, 2047));
            else a[10:0] = 11'($urandom_range(0, 63));
            d = $urandom();
            lg = is_legal(we, c);
            sp = lg && (int'(a[1:0]) + size_of(c) > 4);
            exp_lat = !lg ? 1 : (we ? (sp ? 3 : 2) : (sp ? 4 : 3));
            exp_nb  = !lg ? 0 : (sp ? 2 : 1);
            exp_rd  = (!lg || we) ? 32'h0 : ref_load(a, c);
            do_req(0, we, c, a, d, lat, nb, rd, err);
            check("rnd_err", 32'(err), 32'(!lg));
            check("rnd_lat", 32'(lat), 32'(exp_lat));
            check("rnd_nb", 32'(nb), 32'(exp_nb));
            check("rnd_rd", rd, exp_rd);
            if (lg && we) ref_store(a, c, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store initiator that drives the byte-lane data memory (four 8-bit synchronous RAM banks, word-indexed, 1-cycle read latency) on behalf of the core.
- Accepts one request at a time over a valid/ready handshake.
- Generates word address, per-lane write enables and lane-shifted write data.
- Aligns and sign- or zero-extends read data, and splits misaligned halfword/word accesses into two word beats.

Parameters:
- ADDR_W, 9, width of the memory word index (byte address bits [ADDR_W+1:2]).
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses into two beats; 0 = reject them with resp_err.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  access size code: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal ctrl code, or misaligned access with ALLOW_MISALIGNED=0.
- mem_en  out  1  beat valid.
- mem_we  out  1  beat is a write.
- mem_be  out  4  per-lane write enables; 0000 on reads.
- mem_addr  out  ADDR_W  word index.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read word, valid the cycle after a read beat.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- All mem_* and resp_* outputs are registered.

Accept:
- A request is accepted at edge T when req_valid&&req_ready. All request fields are latched; req_ready drops at T+1.
- req_valid while busy is ignored (not queued).

Legality:
- Load: ctrl in {000,001,010,100,101}. Store: ctrl in {000,001,010}.
- Otherwise: no memory beat; resp_valid=1, resp_err=1, resp_rdata=0 at T+1.

Lane math:
- o = addr[1:0], n = size in bytes (1/2/4), w0 = addr[ADDR_W+1:2].
- Split iff o+n > 4. Beat1 word index = w0+1 modulo 2^ADDR_W (wraps 511 -> 0).
- If split and ALLOW_MISALIGNED=0: error response at T+1, no beat.

States: IDLE, BEAT0, BEAT1, WAIT, RESP.
- IDLE -> BEAT0 on a legal accept.
- BEAT0 (mem_en=1 at T+1):
  - Store: mem_be = lane mask of bytes o..min(o+n,4)-1; mem_wdata = req_wdata << 8*o.
  - Load: mem_be=0000.
  - Split -> BEAT1; else load -> WAIT, store -> RESP.
- BEAT1 (T+2):
  - Store: mem_be = mask of lanes 0..(o+n-5); mem_wdata = req_wdata >> 8*(4-o).
  - The beat-0 read word is captured this cycle.
  - -> WAIT (load) or RESP (store).
- WAIT: captures the final mem_rdata; -> RESP.
- RESP: resp_valid=1 for one cycle; -> IDLE (req_ready=1 next cycle).

Load assembly:
- Single beat: rdata >> 8*o.
- Split: ({beat1, beat0} >> 8*o)[31:0].
- Then extend per ctrl: sign from bit 7/15 for 000/001, zeros for 100/101.

Latency (accept T to resp_valid):
- Single store T+2, split store T+3.
- Single load T+3, split load T+4.
- Error T+1.

Other rules:
- mem_en=0 in every cycle not listed as a beat; mem_we equals latched req_we during beats.
- Reset mid-operation: the next edge forces IDLE and reset values. A pending beat is dropped; a write beat already presented is not retracted.
- resp has no backpressure; the consumer must accept the pulse.

Decomposition:
- Package lsu_mem_pkg holds the ctrl code constants (CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU), the state enum, and a size-from-ctrl function.
- One combinational sub-module, lsu_lane_align, covers byte-enable generation, write-data shifting, read merge/shift and sign/zero extension.
- The FSM and registers stay in the top module.

Test Plan:
- Store word 0xDEADBEEF to 0x10: a single beat at T+1 with mem_addr=4, be=1111, wdata=0xDEADBEEF; resp_valid at T+2, err=0.
- Store byte 0xA5 to 0x13: be=1000, wdata=0xA5000000. Then load ctrl=000 from 0x13 gives resp_rdata=0xFFFFFFA5; ctrl=100 gives 0x000000A5.
- Store word 0x11223344 to 0x0E: beat0 addr=3, be=1100, wdata=0x33440000; beat1 addr=4, be=0011, wdata=0x00001122. Loading word from 0x0E returns 0x11223344 at T+4.
- Half store 0x8001 at byte 0x7FF (w0=511): beat0 be=1000 at addr 511, beat1 be=0001 at addr 0 (wrap). Half-signed load returns 0xFFFF8001.
- Illegal ctrl 011, or store ctrl=100: no mem_en; resp_valid with resp_err=1, rdata=0 at T+1. With ALLOW_MISALIGNED=0, a word load from 0x02 errors the same way.
- Assert rst during BEAT1 of a split store: the next cycle shows mem_en=0, state IDLE, req_ready=1, and resp_valid never pulses.
